// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads (absolute priority) and two round-robin writers.
// Build option: define FB_ARB_BLANK_ONLY_EN to grant writers only while I_video_on is low.
module fb_arbiter #(
    parameter int C_H_START  = 144,
    parameter int C_V_START  = 35,
    parameter int C_FB_WIDTH = 160,
    parameter int C_FB_DEPTH = 19200
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_p_tick,
    input  logic        I_video_on,
    input  logic [9:0]  I_x,
    input  logic [9:0]  I_y,
    input  logic        I_wr0_req,
    input  logic        I_wr1_req,
    input  logic [14:0] I_wr0_addr,
    input  logic [14:0] I_wr1_addr,
    input  logic [7:0]  I_wr0_data,
    input  logic [7:0]  I_wr1_data,
    output logic        O_wr0_ack,
    output logic        O_wr1_ack,
    output logic [14:0] O_mem_addr,
    output logic        O_mem_we,
    output logic [7:0]  O_mem_wdata,
    input  logic [7:0]  I_mem_rdata,
    output logic [7:0]  O_rgb,
    output logic [7:0]  O_frame_cnt
);

    // state  | meaning
    // S_IDLE | nobody owns the memory, address holds
    // S_DISP | display read of the current pixel
    // S_WR0  | writer 0 owns the memory (ack0 high)
    // S_WR1  | writer 1 owns the memory (ack1 high)
    typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR0, S_WR1} state_t;

    localparam logic [9:0]  H_FIRST = 10'(C_H_START);
    localparam logic [9:0]  H_LAST  = 10'(C_H_START + 639);
    localparam logic [9:0]  V_FIRST = 10'(C_V_START);
    localparam logic [9:0]  V_LAST  = 10'(C_V_START + 479);
    localparam logic [9:0]  Y_WRAP  = 10'd524;
    localparam logic [14:0] FB_W    = 15'(C_FB_WIDTH);
    localparam logic [14:0] FB_D    = 15'(C_FB_DEPTH);

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        last_q, last_d;
    logic        vid_d1, vid_d2, rd_d2;
    logic [7:0]  rgb_q;
    logic [9:0]  y_prev_q;
    logic [7:0]  frame_q;

    logic [9:0]  dx, dy;
    logic [14:0] disp_addr;
    logic        disp_slot;
    logic        wr_allowed;
    logic        req0_ok, req1_ok, grant0, grant1;

    // Row base as a constant-coefficient shift/add sum; collapses to two adders for width 160.
    function automatic logic [14:0] row_base(input logic [7:0] row);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            if (FB_W[i]) acc = acc + (15'(row) << i);
        end
        return acc;
    endfunction

    assign dx        = I_x - H_FIRST;
    assign dy        = I_y - V_FIRST;
    assign disp_addr = row_base(dy[9:2]) + {7'd0, dx[9:2]};
    assign disp_slot = ~I_p_tick & I_video_on
                     & (I_x >= H_FIRST) & (I_x <= H_LAST)
                     & (I_y >= V_FIRST) & (I_y <= V_LAST);

`ifdef FB_ARB_BLANK_ONLY_EN
    assign wr_allowed = ~I_video_on;
`else
    assign wr_allowed = 1'b1;
`endif

    // A writer being acked this cycle still shows req at the edge, so it is masked once.
    assign req0_ok = I_wr0_req & (state_q != S_WR0) & wr_allowed;
    assign req1_ok = I_wr1_req & (state_q != S_WR1) & wr_allowed;
    assign grant1  = req1_ok & (~req0_ok | ~last_q);
    assign grant0  = req0_ok & ~grant1;

    always_comb begin
        state_d = S_IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        last_d  = last_q;
        if (disp_slot) begin
            state_d = S_DISP;
            addr_d  = disp_addr;
        end else if (grant0) begin
            state_d = S_WR0;
            last_d  = 1'b0;
            if (I_wr0_addr < FB_D) begin
                we_d    = 1'b1;
                addr_d  = I_wr0_addr;
                wdata_d = I_wr0_data;
            end
        end else if (grant1) begin
            state_d = S_WR1;
            last_d  = 1'b1;
            if (I_wr1_addr < FB_D) begin
                we_d    = 1'b1;
                addr_d  = I_wr1_addr;
                wdata_d = I_wr1_data;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            last_q  <= last_d;
        end
    end

    // Read return path: address cycle, RAM cycle, then O_rgb loads.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            vid_d1 <= 1'b0;
            vid_d2 <= 1'b0;
            rd_d2  <= 1'b0;
            rgb_q  <= '0;
        end else begin
            vid_d1 <= I_video_on;
            vid_d2 <= vid_d1;
            rd_d2  <= (state_q == S_DISP);
            if (!vid_d2)
                rgb_q <= '0;
            else if (rd_d2)
                rgb_q <= I_mem_rdata;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            y_prev_q <= '0;
            frame_q  <= '0;
        end else begin
            y_prev_q <= I_y;
            if (y_prev_q == Y_WRAP && I_y == 10'd0)
                frame_q <= frame_q + 8'd1;
        end
    end

    assign O_wr0_ack   = (state_q == S_WR0);
    assign O_wr1_ack   = (state_q == S_WR1);
    assign O_mem_addr  = addr_q;
    assign O_mem_we    = we_q;
    assign O_mem_wdata = wdata_q;
    assign O_rgb       = rgb_q;
    assign O_frame_cnt = frame_q;

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter C_H_START, default 144, first active horizontal count.
REQ-002 Parameter C_V_START, default 35, first active vertical count.
REQ-003 Parameter C_FB_WIDTH, default 160, framebuffer pixels per row (fixed 4x downscale of 640x480).
REQ-004 Parameter C_FB_DEPTH, default 19200, framebuffer word count.
REQ-005 I_clk  in  1  system 50 MHz clock; the only clock.
REQ-006 I_rst  in  1  reset, synchronous, active-high.
REQ-007 I_p_tick  in  1  25 MHz pixel enable from the timing generator.
REQ-008 I_video_on  in  1  active-region flag from the timing generator.
REQ-009 I_x, I_y  in  10 each  raw horizontal/vertical counts.
REQ-010 I_wr0_req, I_wr1_req  in  1 each  writer requests.
REQ-011 I_wr0_addr, I_wr1_addr  in  15 each  writer word addresses.
REQ-012 I_wr0_data, I_wr1_data  in  8 each  writer RGB332 data.
REQ-013 O_wr0_ack, O_wr1_ack  out  1 each  one-cycle grant/completion pulses.
REQ-014 O_mem_addr  out  15, O_mem_we  out  1, O_mem_wdata  out  8: single-port framebuffer drive.
REQ-015 I_mem_rdata  in  8  memory read data, valid one cycle after address with O_mem_we=0.
REQ-016 O_rgb  out  8  display pixel; O_frame_cnt  out  8  completed-frame counter.

Function
REQ-017 Memory ownership per cycle SHALL be set by an FSM with states S_IDLE, S_DISP, S_WR0, S_WR1; exactly one owner per cycle.
REQ-018 Display slot: cycle with I_p_tick=0, I_video_on=1, I_x in [C_H_START, C_H_START+639], I_y in [C_V_START, C_V_START+479]; FSM SHALL enter S_DISP, display has absolute priority.
REQ-019 Display address SHALL be ((I_y-C_V_START)>>2)*C_FB_WIDTH + ((I_x-C_H_START)>>2), computed with shifts/adds, no multiplier, 15-bit result.
REQ-020 O_rgb SHALL load I_mem_rdata two cycles after the display slot; O_rgb SHALL be 0 when the delayed video_on is 0.
REQ-021 Non-display cycles with any writer request SHALL enter S_WR0 or S_WR1; O_mem_we=1, addr/data from granted writer, matching ack pulsed in the same cycle.
REQ-022 Both writers requesting: grant the writer not served last (round-robin pointer); single requester granted directly.
REQ-023 Writer holds req, addr, data stable until ack; ack never asserted twice for one cycle of req; back-to-back grants to the same writer allowed only if the other is idle.
REQ-024 Writer address >= C_FB_DEPTH: ack SHALL pulse, O_mem_we SHALL stay 0.
REQ-025 No owner: S_IDLE, O_mem_we=0, O_mem_addr holds.
REQ-026 O_frame_cnt SHALL increment (mod 256) once when I_y wraps from 524 to 0.
REQ-027 Request and display slot in the same cycle: display served, request waits; no request lost.

Reset
REQ-028 I_rst sampled high SHALL force S_IDLE, O_mem_we=0, O_mem_addr=0, O_mem_wdata=0, acks=0, O_rgb=0, O_frame_cnt=0, pointer=writer0 favoured; pending pipelined read discarded.
REQ-029 Reset mid-write SHALL deassert O_mem_we next edge; unacked request re-served after reset.

Configuration
REQ-030 Macro FB_ARB_BLANK_ONLY_EN: defined -> writers granted only when I_video_on=0 (tear-free); undefined -> writers granted in any non-display cycle.

Verification
REQ-031 I_x=144, I_y=35, p_tick=0, video_on=1 -> O_mem_addr=0, O_mem_we=0; I_mem_rdata=0xE0 -> O_rgb=0xE0 two cycles later.
REQ-032 I_x=783, I_y=514 display slot -> O_mem_addr=19199.
REQ-033 Both writers hold req in blanking -> acks alternate wr0, wr1, wr0...; O_mem_we=1 each grant.
REQ-034 wr0 req addr=19200 -> O_wr0_ack pulses, O_mem_we stays 0.
REQ-035 Writer req during active line: macro undefined -> acked in p_tick=1 cycle; macro defined -> no ack until video_on=0.
REQ-036 Three full frames simulated -> O_frame_cnt=3; I_rst asserted mid-write -> all outputs zero next cycle.
